// File: rtl/conv_fprop_mac_acc.sv
// Pipelined signed MAC: NUM_STAGE product registers feed a first/last-framed accumulator.
// Define CONV_FPROP_MAC_SAT_EN to clamp dout to its signed range and flag out_ovf.
module conv_fprop_mac_acc #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int acc_WIDTH  = 40,
  parameter int dout_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  logic signed [PW-1:0]         r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]         r_vld;
  logic [NUM_STAGE-1:0]         r_first;
  logic [NUM_STAGE-1:0]         r_last;
  logic signed [acc_WIDTH-1:0]  r_acc;
  logic signed [dout_WIDTH-1:0] r_dout;
  logic                         r_out_valid;
  logic                         r_out_ovf;

  logic signed [PW-1:0]         w_prod;
  logic signed [acc_WIDTH-1:0]  w_prod_ext;
  logic signed [acc_WIDTH-1:0]  w_acc_nxt;
  logic signed [dout_WIDTH-1:0] w_dout;
  logic                         w_ovf;

  assign w_prod     = PW'(din0) * PW'(din1);
  assign w_prod_ext = acc_WIDTH'(r_prod[NUM_STAGE-1]);
  assign w_acc_nxt  = r_first[NUM_STAGE-1] ? w_prod_ext : r_acc + w_prod_ext;

`ifdef CONV_FPROP_MAC_SAT_EN
  // Value fits iff every bit from the dout sign position upward agrees.
  logic [acc_WIDTH-dout_WIDTH:0] w_hi;
  assign w_hi  = w_acc_nxt[acc_WIDTH-1:dout_WIDTH-1];
  assign w_ovf = ~((&w_hi) | (~|w_hi));
  assign w_dout = !w_ovf ? w_acc_nxt[dout_WIDTH-1:0] :
                  w_acc_nxt[acc_WIDTH-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}} :
                                           {1'b0, {(dout_WIDTH-1){1'b1}}};
`else
  assign w_ovf  = 1'b0;
  assign w_dout = w_acc_nxt[dout_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld       <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_acc       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (ce) begin
      r_vld[0]   <= in_valid;
      r_first[0] <= in_first;
      r_last[0]  <= in_last;
      r_prod[0]  <= w_prod;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
        r_prod[i]  <= r_prod[i-1];
      end
      r_out_valid <= 1'b0;
      if (r_vld[NUM_STAGE-1]) begin
        r_acc <= w_acc_nxt;
        if (r_last[NUM_STAGE-1]) begin
          r_dout      <= w_dout;
          r_out_ovf   <= w_ovf;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_conv_fprop_mac_acc.sv
// Directed plus randomized bench for conv_fprop_mac_acc against a transaction-level sum model.
// Honours CONV_FPROP_MAC_SAT_EN the same way as the design.
module tb_conv_fprop_mac_acc;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [15:0] din0, din1;
  logic out_valid, out_ovf;
  logic signed [31:0] dout;

  conv_fprop_mac_acc #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(16), .din1_WIDTH(16),
                       .acc_WIDTH(40), .dout_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid),
    .dout(dout), .out_ovf(out_ovf));

  always #5 clk = ~clk;

  typedef struct {int due; longint d; bit o;} exp_t;
  exp_t   q[$];
  int     checks = 0, failures = 0;
  int     n = 0;
  longint m_acc = 0;
  bit     e_ov = 0, e_o = 0;
  longint e_d = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Map a 40-bit two's-complement sum onto the 32-bit result.
  function automatic void fold(input longint acc, output longint d, output bit o);
    longint s;
    int t;
    s = (acc <<< 24) >>> 24;
`ifdef CONV_FPROP_MAC_SAT_EN
    if (s > 64'sd2147483647) begin d = 64'sd2147483647; o = 1'b1; end
    else if (s < -64'sd2147483648) begin d = -64'sd2147483648; o = 1'b1; end
    else begin d = s; o = 1'b0; end
`else
    t = s[31:0];
    d = t;
    o = 1'b0;
`endif
  endfunction

  task automatic step(input bit c, input bit v, input bit f, input bit l, input int a, input int b);
    longint p, d;
    bit o;
    shortint sa, sb;
    ce = c; in_valid = v; in_first = f; in_last = l;
    din0 = 16'(a); din1 = 16'(b);
    sa = 16'(a); sb = 16'(b);
    @(posedge clk);
    if (c) begin
      n++;
      if (v) begin
        p = longint'(sa) * longint'(sb);
        m_acc = (f ? p : m_acc + p) & 64'h0000_00FF_FFFF_FFFF;
        if (l) begin
          fold(m_acc, d, o);
          q.push_back('{n + NS, d, o});
        end
      end
      e_ov = 1'b0;
      if (q.size() > 0 && q[0].due == n) begin
        e_ov = 1'b1; e_d = q[0].d; e_o = q[0].o;
        void'(q.pop_front());
      end
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    chk("dout", 64'(dout), e_d);
    chk("out_ovf", {63'd0, out_ovf}, {63'd0, e_o});
  endtask

  task automatic do_reset(input bit c);
    reset = 1'b1; ce = c; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete(); m_acc = 0; e_ov = 0; e_d = 0; e_o = 0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // single first+last product, result three cycles later for one cycle
    step(1, 1, 1, 1, -3, 7);
    step(1, 0, 0, 0, 0, 0);
    chk("single_early", {63'd0, out_valid}, 64'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("single_dout", 64'(dout), -64'sd21);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    idle(1);
    chk("single_pulse", {63'd0, out_valid}, 64'd0);

    // three-beat sum followed back-to-back by a single-product sum
    step(1, 1, 1, 0, 2, 3);
    step(1, 1, 0, 0, 4, 5);
    step(1, 1, 0, 1, -1, 6);
    step(1, 1, 1, 1, 10, 10);
    step(1, 0, 0, 0, 0, 0);
    chk("b2b_first", 64'(dout), 64'sd20);
    step(1, 0, 0, 0, 0, 0);
    chk("b2b_second", 64'(dout), 64'sd100);
    chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    idle(2);

    // ce stall mid-sum delays the result by the stall length
    step(1, 1, 1, 0, 2, 3);
    step(1, 1, 0, 0, 4, 5);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, -1, 6);
    step(1, 0, 0, 0, 0, 0);
    chk("stall_early", {63'd0, out_valid}, 64'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("stall_dout", 64'(dout), 64'sd20);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_hold", {63'd0, out_valid}, 64'd1);
    idle(2);

    // overflow of the 32-bit result
    step(1, 1, 1, 0, 32767, 32767);
    step(1, 1, 0, 0, 32767, 32767);
    step(1, 1, 0, 1, 32767, 32767);
    idle(2);
`ifdef CONV_FPROP_MAC_SAT_EN
    chk("ovf_dout", 64'(dout), 64'sd2147483647);
    chk("ovf_flag", {63'd0, out_ovf}, 64'd1);
`else
    chk("ovf_dout", 64'(dout), -64'sd1073938429);
    chk("ovf_flag", {63'd0, out_ovf}, 64'd0);
`endif
    idle(1);

    // reset mid-sum drops in-flight beats and clears acc
    step(1, 1, 1, 0, 1, 2);
    do_reset(1'b1);
    idle(3);
    step(1, 1, 0, 1, 5, 5);
    idle(2);
    chk("rst_mid_dout", 64'(dout), 64'sd25);
    idle(2);

    // continuation onto previous acc without a new first beat
    step(1, 1, 0, 1, 3, 3);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int a, b;
      bit c, v, f, l;
      c = ($urandom_range(0, 9) < 8);
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 32767 : -32768)
                                      : int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      step(c, v, f, l, a, b);
      if (i == 200) do_reset($urandom_range(0, 1) == 1);
    end
    idle(NS + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
